// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared memory-map definitions for the CPU data-memory responder:
//   default MMIO window base, MMIO register offsets, STATUS bit positions
//   and the address-region decode helper.
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_FF00;

  // Register offsets inside the MMIO window (low 8 address bits).
  typedef enum logic [7:0] {
    OFF_LED    = 8'h00,
    OFF_SW     = 8'h01,
    OFF_CYCLE  = 8'h02,
    OFF_STATUS = 8'h03
  } mmio_off_e;

  localparam int unsigned STAT_OVF_BIT     = 0;
  localparam int unsigned STAT_BUS_ERR_BIT = 1;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_UNMAPPED
  } region_e;

  // RAM occupies word addresses [0, 2**addr_w); the MMIO window is the
  // 256-word block whose upper 24 bits match the base.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned addr_w,
                                            input logic [31:0] base);
    if ((addr >> addr_w) == 32'd0) return REGION_RAM;
    if (addr[31:8] == base[31:8])  return REGION_MMIO;
    return REGION_UNMAPPED;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//   CPU data-memory bus.
//   MemEn   : access strobe, one cycle per access
//   MemWen  : 1 = store, 0 = load (ignored when MemEn = 0)
//   addr_in : 32-bit word address
//   wdata   : store data
//   rdata   : registered load data, valid one cycle after the strobe
//   master = CPU side, slave = responder side.
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        MemEn;
  logic        MemWen;
  logic [31:0] addr_in;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output MemEn, output MemWen, output addr_in, output wdata,
                  input  rdata);
  modport slave  (input  MemEn, input  MemWen, input  addr_in, input  wdata,
                  output rdata);
endinterface

// File: rtl/data_mem_responder_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a bus of quasi-static asynchronous inputs
//   (board switches). Each bit is synchronised independently.
//   clk   : destination clock
//   reset : asynchronous, active-high; clears both stages
//   d_i   : asynchronous input
//   q_o   : synchronised output (2 clk of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the CPU data-memory interface. Every load/store is
//   decoded into a word-addressed block RAM or a small MMIO window:
//     +0x00 LED    (RW, low SW_W bits)
//     +0x01 SW     (RO, synchronised switches, zero-extended)
//     +0x02 CYCLE  (RW, free-running counter; a store loads it)
//     +0x03 STATUS (RO, bit0 counter overflow, bit1 bus error)
//   Ports:
//     clk, reset : system clock / async active-high reset
//     bus        : CPU data bus (slave modport)
//     sw_in      : asynchronous board switches
//     led_out    : LED register contents
//     bus_err    : sticky flag, an unmapped or read-only store was seen
// ----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
  parameter int unsigned SW_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  input  logic [SW_W-1:0]      sw_in,
  output logic [SW_W-1:0]      led_out,
  output logic                 bus_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  region_e           region;
  logic              is_load;
  logic              is_store;
  logic [ADDR_W-1:0] word;
  logic [7:0]        offset;
  logic [SW_W-1:0]   sw_sync;

  logic [SW_W-1:0]   led_q,     led_d;
  logic [31:0]       cyc_q,     cyc_d;
  logic              ovf_q,     ovf_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       mmio_rd_q, mmio_rd_d;
  logic              sel_ram_q, sel_ram_d;   // rdata source of the last load
  logic [31:0]       ram_rd_q;
  logic              ram_we;
  logic              ram_re;

  logic [31:0]       ram [DEPTH];

  sync_2ff #(.W(SW_W)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw_in),
    .q_o   (sw_sync)
  );

  assign region   = decode_region(bus.addr_in, ADDR_W, MMIO_BASE);
  assign is_load  = bus.MemEn & ~bus.MemWen;
  assign is_store = bus.MemEn &  bus.MemWen;
  assign word     = bus.addr_in[ADDR_W-1:0];
  assign offset   = bus.addr_in[7:0];

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    led_d     = led_q;
    cyc_d     = cyc_q + 32'd1;
    ovf_d     = ovf_q | (&cyc_q);            // wrap from all-ones is sticky
    bus_err_d = bus_err_q;
    mmio_rd_d = mmio_rd_q;
    sel_ram_d = sel_ram_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    if (is_store) begin
      case (region)
        REGION_RAM:  ram_we = ~reset;        // reset aborts an in-flight store
        REGION_MMIO: begin
          case (offset)
            OFF_LED:   led_d = bus.wdata[SW_W-1:0];
            OFF_CYCLE: begin
              cyc_d = bus.wdata;             // CPU store wins over increment
              ovf_d = ovf_q;
            end
            default:   bus_err_d = 1'b1;     // SW, STATUS, unmapped offsets
          endcase
        end
        default:     bus_err_d = 1'b1;
      endcase
    end

    if (is_load) begin
      sel_ram_d = 1'b0;
      case (region)
        REGION_RAM: begin
          ram_re    = 1'b1;
          sel_ram_d = 1'b1;
        end
        REGION_MMIO: begin
          case (offset)
            OFF_LED:    mmio_rd_d = 32'(led_q);
            OFF_SW:     mmio_rd_d = 32'(sw_sync);
            OFF_CYCLE:  mmio_rd_d = cyc_q;   // value before this edge's increment
            OFF_STATUS: begin
              mmio_rd_d                   = '0;
              mmio_rd_d[STAT_OVF_BIT]     = ovf_q;
              mmio_rd_d[STAT_BUS_ERR_BIT] = bus_err_q;
            end
            default: begin
              mmio_rd_d = '0;
              bus_err_d = 1'b1;
            end
          endcase
        end
        default: begin
          mmio_rd_d = '0;
          bus_err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      cyc_q     <= '0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
      mmio_rd_q <= '0;
      sel_ram_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      cyc_q     <= cyc_d;
      ovf_q     <= ovf_d;
      bus_err_q <= bus_err_d;
      mmio_rd_q <= mmio_rd_d;
      sel_ram_q <= sel_ram_d;
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map
  // onto block RAM; after reset sel_ram_q steers rdata away from them.
  always_ff @(posedge clk) begin
    if (ram_we) ram[word] <= bus.wdata;
    if (ram_re) ram_rd_q  <= ram[word];
  end

  assign bus.rdata = sel_ram_q ? ram_rd_q : mmio_rd_q;
  assign led_out   = led_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder. A transaction-level model tracks
//   RAM contents, LED, sticky flags, the counter (as load value + elapsed
//   edges) and the switch history; a negedge process compares rdata, led_out
//   and bus_err against it every cycle. Literal checks pin key values.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

  typedef longint unsigned u64_t;

  localparam logic [31:0] MMIO = 32'hFFFF_FF00;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] sw_in  = 16'h0;
  logic [15:0] led_out;
  logic        bus_err;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .ADDR_W    (10),
    .MMIO_BASE (MMIO),
    .SW_W      (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .sw_in   (sw_in),
    .led_out (led_out),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [int];
  logic [15:0] sw_at [int];     // sw_in as seen at each counted edge
  logic [15:0] led_m;
  logic        bus_err_m;
  logic        ovf_m;
  logic [31:0] rdata_m;
  bit          rdata_known;
  bit          chk_en = 0;
  u64_t        load_val;        // counter value before edge load_edge
  int          load_edge;
  int          edge_n = 0;      // index of the next counted edge
  int          sw_from;         // first edge after reset release

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    led_m       = '0;
    bus_err_m   = 1'b0;
    ovf_m       = 1'b0;
    rdata_m     = '0;
    rdata_known = 1;
    load_val    = 0;
    load_edge   = edge_n;
    sw_from     = edge_n;
  endtask

  // Applies one access at counted edge edge_n using pre-edge model state.
  task automatic model_apply(input logic en, input logic wen,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [15:0] sw);
    u64_t        elapsed    = u64_t'(edge_n - load_edge);
    logic [31:0] cnt_pre    = 32'(load_val + elapsed);
    logic [15:0] sync_pre   = (edge_n - 2 >= sw_from) ? sw_at[edge_n-2] : 16'h0;
    logic [31:0] status_pre = {30'd0, bus_err_m, ovf_m};
    bit          cyc_written = 0;
    bit          is_ram  = (a < 32'd1024);
    bit          is_mmio = (a[31:8] == 24'hFF_FFFF);
    sw_at[edge_n] = sw;
    if (en && wen) begin
      if (is_ram)                        mem_m[int'(a)] = d;
      else if (is_mmio && a[7:0] == 8'h00) led_m = d[15:0];
      else if (is_mmio && a[7:0] == 8'h02) begin
        load_val    = u64_t'(d);
        load_edge   = edge_n + 1;
        cyc_written = 1;
      end
      else bus_err_m = 1'b1;
    end else if (en) begin
      rdata_known = 1;
      if (is_ram) begin
        if (mem_m.exists(int'(a))) rdata_m = mem_m[int'(a)];
        else rdata_known = 0;
      end
      else if (is_mmio && a[7:0] == 8'h00) rdata_m = {16'h0, led_m};
      else if (is_mmio && a[7:0] == 8'h01) rdata_m = {16'h0, sync_pre};
      else if (is_mmio && a[7:0] == 8'h02) rdata_m = cnt_pre;
      else if (is_mmio && a[7:0] == 8'h03) rdata_m = status_pre;
      else begin
        rdata_m   = '0;
        bus_err_m = 1'b1;
      end
    end
    if (!cyc_written &&
        (load_val + u64_t'(edge_n + 1 - load_edge)) >= 64'h1_0000_0000)
      ovf_m = 1'b1;
    edge_n++;
  endtask

  // One bus cycle: drive, let the edge happen, advance the model.
  task automatic cyc(input logic en, input logic wen,
                     input logic [31:0] a, input logic [31:0] d);
    bus.MemEn   = en;
    bus.MemWen  = wen;
    bus.addr_in = a;
    bus.wdata   = d;
    @(posedge clk);
    model_apply(en, wen, a, d, sw_in);
    #1;
  endtask

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (rdata_known) check("rdata", bus.rdata, rdata_m);
      check("led_out", 32'(led_out), 32'(led_m));
      check("bus_err", 32'(bus_err), 32'(bus_err_m));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.MemEn   = 1'b0;
    bus.MemWen  = 1'b0;
    bus.addr_in = '0;
    bus.wdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1;
    check("rst_rdata",   bus.rdata,        32'h0);
    check("rst_led",     32'(led_out),     32'h0);
    check("rst_bus_err", 32'(bus_err),     32'h0);

    // 1. RAM store/load, read-after-write, last word, stores leave rdata alone
    cyc(1, 0, 32'd5, '0);
    cyc(1, 1, 32'd5, 32'hA5A5_1234);
    cyc(1, 0, 32'd5, '0);
    check("t1_raw", bus.rdata, 32'hA5A5_1234);
    cyc(1, 1, 32'd1023, 32'h1357_9BDF);
    cyc(1, 0, 32'd1023, '0);
    check("t1_last_word", bus.rdata, 32'h1357_9BDF);
    cyc(1, 1, 32'd0, 32'hCAFE_0000);
    check("t1_store_holds", bus.rdata, 32'h1357_9BDF);
    cyc(0, 0, 32'd0, '0);
    check("t1_idle_holds", bus.rdata, 32'h1357_9BDF);
    cyc(1, 0, 32'd0, '0);
    check("t1_word0", bus.rdata, 32'hCAFE_0000);

    // 2. LED register
    cyc(1, 1, MMIO + 32'h0, 32'h0000_00FF);
    check("t2_led", 32'(led_out), 32'h0000_00FF);
    cyc(1, 0, MMIO + 32'h0, '0);
    check("t2_led_rd", bus.rdata, 32'h0000_00FF);
    cyc(1, 1, MMIO + 32'h0, 32'hABCD_1234);
    check("t2_led_trunc", 32'(led_out), 32'h0000_1234);

    // 3. switch synchroniser latency
    sw_in = 16'h00C3;
    cyc(1, 0, MMIO + 32'h1, '0);
    check("t3_sw_old", bus.rdata, 32'h0);
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, '0);
    cyc(1, 0, MMIO + 32'h1, '0);
    check("t3_sw_new", bus.rdata, 32'h0000_00C3);

    // 4. cycle counter load, wrap and overflow flag
    cyc(1, 1, MMIO + 32'h2, 32'hFFFF_FFFE);
    cyc(1, 0, MMIO + 32'h2, '0);
    check("t4_cyc_fffe", bus.rdata, 32'hFFFF_FFFE);
    cyc(1, 0, MMIO + 32'h2, '0);
    check("t4_cyc_ffff", bus.rdata, 32'hFFFF_FFFF);
    cyc(1, 0, MMIO + 32'h2, '0);
    check("t4_cyc_wrap", bus.rdata, 32'h0);
    cyc(1, 0, MMIO + 32'h3, '0);
    check("t4_status_ovf", bus.rdata, 32'h0000_0001);

    // 5. unmapped / read-only accesses
    cyc(1, 0, 32'd1024, '0);
    check("t5_ram_edge_rd", bus.rdata, 32'h0);
    check("t5_ram_edge_err", 32'(bus_err), 32'h1);
    cyc(1, 0, MMIO + 32'h0, '0);
    cyc(1, 0, 32'h0001_0000, '0);
    check("t5_unmapped_rd", bus.rdata, 32'h0);
    cyc(1, 0, MMIO + 32'h3, '0);
    check("t5_status_both", bus.rdata, 32'h0000_0003);
    cyc(1, 1, MMIO + 32'h1, 32'h0000_FFFF);
    cyc(1, 0, MMIO + 32'h1, '0);
    check("t5_sw_ro", bus.rdata, 32'h0000_00C3);
    check("t5_led_kept", 32'(led_out), 32'h0000_1234);
    cyc(1, 1, MMIO + 32'h4, 32'h1111_1111);
    cyc(1, 0, MMIO + 32'h4, '0);
    check("t5_off4_rd", bus.rdata, 32'h0);
    check("t5_err_sticky", 32'(bus_err), 32'h1);

    // 6. asynchronous reset in the middle of a store
    cyc(1, 0, MMIO + 32'h0, '0);
    bus.MemEn   = 1'b1;
    bus.MemWen  = 1'b1;
    bus.addr_in = MMIO + 32'h0;
    bus.wdata   = 32'h0000_5555;
    #2;
    reset = 1'b1;
    #1;
    check("t6_rdata_async",   bus.rdata,    32'h0);
    check("t6_led_async",     32'(led_out), 32'h0);
    check("t6_bus_err_async", 32'(bus_err), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus.MemEn  = 1'b0;
    bus.MemWen = 1'b0;
    model_reset();
    cyc(1, 0, MMIO + 32'h2, '0);
    check("t6_cyc_cleared", bus.rdata, 32'h0);
    cyc(1, 0, MMIO + 32'h3, '0);
    check("t6_status_clr", bus.rdata, 32'h0);
    cyc(1, 0, MMIO + 32'h0, '0);
    check("t6_led_clr", bus.rdata, 32'h0);
    cyc(1, 0, MMIO + 32'h1, '0);
    check("t6_sw_resync", bus.rdata, 32'h0000_00C3);
    cyc(0, 0, '0, '0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
